// File: rtl/rtc_bus_responder_if.sv
// Control half of the RTC multiplexed bus: chip select, address/data phase select and the
// two active-low strobes. The shared 8-bit DatAdd lines stay a plain inout on the responder.
interface rtc_bus_responder_if;
    logic CS;
    logic AD;
    logic RD;
    logic WR;

    modport master (output CS, AD, RD, WR);
    modport slave  (input  CS, AD, RD, WR);
endinterface

// File: rtl/rtc_bus_responder.sv
// Stand-in for the external RTC chip: BCD clock/calendar, countdown timer with active-low irq,
// and the slave side of the multiplexed CS/AD/RD/WR/DatAdd bus.
module rtc_bus_responder #(
    parameter int TICK_DIV = 100000000
) (
    input  logic                clk,
    input  logic                reset,
    rtc_bus_responder_if.slave  bus,
    inout  wire  [7:0]          DatAdd,
    output logic                irq
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

    state_t           state;
    state_t           state_nx;
    logic             wr_q;
    logic             wr_rise;
    logic             addr_we;
    logic             reg_we;
    logic             rd_cap;
    logic             drive;
    logic [7:0]       addr;
    logic [7:0]       wdata;
    logic [7:0]       rd_mux;
    logic [7:0]       rd_data;
    logic [CNT_W-1:0] cnt;
    logic             tick;

    logic [7:0] ctrl;
    logic [7:0] sec;
    logic [7:0] minute;
    logic [7:0] hour;
    logic [7:0] day;
    logic [7:0] month;
    logic [7:0] year;
    logic [7:0] tmr_sec;
    logic [7:0] tmr_min;

    logic [7:0] sec_adv, min_adv, hour_adv, day_adv, month_adv, year_adv;
    logic [7:0] tmr_sec_dec, tmr_min_dec;
    logic       time_wr, tmr_wr, irq_clr, adv_en, tmr_run, dec_en, tmr_expire;

    // {carry, next}. Low nibble >= 9 carries; reaching the limit, or a high nibble pushed past
    // the limit's high nibble, wraps to the field's reset value and carries out.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim,
                                           input logic [7:0] wrap_val);
        logic [4:0] hi;
        logic [7:0] r;
        logic       c;
        hi = 5'd0;
        r  = v;
        c  = 1'b0;
        if (v == lim) begin
            r = wrap_val;
            c = 1'b1;
        end else if (v[3:0] >= 4'd9) begin
            hi = {1'b0, v[7:4]} + 5'd1;
            if (hi > {1'b0, lim[7:4]}) begin
                r = wrap_val;
                c = 1'b1;
            end else begin
                r = {hi[3:0], 4'h0};
            end
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return {c, r};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'h9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Bus sampling and strobe edge detection
    always_ff @(posedge clk) begin
        if (!reset)
            wr_q <= 1'b1;
        else
            wr_q <= bus.WR;
    end

    assign wr_rise = !wr_q && bus.WR;
    assign wdata   = DatAdd;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (!bus.CS && !(!bus.WR && !bus.RD)) begin
                    if (!bus.AD && !bus.WR)
                        state_nx = ADDR;
                    else if (bus.AD && !bus.WR)
                        state_nx = WDATA;
                    else if (bus.AD && !bus.RD)
                        state_nx = RDATA;
                end
            end
            ADDR, WDATA: begin
                if (bus.CS || wr_rise)
                    state_nx = IDLE;
            end
            RDATA: begin
                if (bus.CS || bus.RD)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs. The read driver drops combinationally on RD/CS high or reset low.
    always_comb begin
        addr_we = 1'b0;
        reg_we  = 1'b0;
        rd_cap  = 1'b0;
        drive   = 1'b0;
        case (state)
            IDLE:    rd_cap  = (state_nx == RDATA);
            ADDR:    addr_we = !bus.CS && wr_rise;
            WDATA:   reg_we  = !bus.CS && wr_rise;
            RDATA:   drive   = !bus.CS && !bus.RD && reset;
            default: ;
        endcase
    end

    assign DatAdd = drive ? rd_data : 8'bz;

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            8'h00:   rd_mux = ctrl;
            8'h21:   rd_mux = sec;
            8'h22:   rd_mux = minute;
            8'h23:   rd_mux = hour;
            8'h24:   rd_mux = day;
            8'h25:   rd_mux = month;
            8'h26:   rd_mux = year;
            8'h41:   rd_mux = tmr_sec;
            8'h42:   rd_mux = tmr_min;
            default: rd_mux = 8'h00;
        endcase
    end

    // Read value is frozen at RDATA entry so it cannot change under a tick mid-read.
    always_ff @(posedge clk) begin
        if (rd_cap)
            rd_data <= rd_mux;
    end

    // One-second tick; free-running even while the clock is halted
    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    assign tick = (cnt == CNT_LAST);

    // Calendar advance: each field steps only when every field below it wrapped.
    always_comb begin
        logic [8:0] r;
        logic       carry;
        r         = bcd_inc(sec, 8'h59, 8'h00);
        sec_adv   = r[7:0];
        carry     = r[8];
        r         = bcd_inc(minute, 8'h59, 8'h00);
        min_adv   = carry ? r[7:0] : minute;
        carry     = carry & r[8];
        r         = bcd_inc(hour, 8'h23, 8'h00);
        hour_adv  = carry ? r[7:0] : hour;
        carry     = carry & r[8];
        r         = bcd_inc(day, 8'h31, 8'h01);
        day_adv   = carry ? r[7:0] : day;
        carry     = carry & r[8];
        r         = bcd_inc(month, 8'h12, 8'h01);
        month_adv = carry ? r[7:0] : month;
        carry     = carry & r[8];
        r         = bcd_inc(year, 8'h99, 8'h00);
        year_adv  = carry ? r[7:0] : year;
    end

    always_comb begin
        tmr_sec_dec = tmr_sec;
        tmr_min_dec = tmr_min;
        if (tmr_sec == 8'h00) begin
            tmr_sec_dec = 8'h59;
            tmr_min_dec = bcd_dec(tmr_min);
        end else begin
            tmr_sec_dec = bcd_dec(tmr_sec);
        end
    end

    // A bus write to a group suppresses that group's update on a coinciding tick.
    assign time_wr    = reg_we && (addr >= 8'h21) && (addr <= 8'h26);
    assign tmr_wr     = reg_we && ((addr == 8'h41) || (addr == 8'h42));
    assign irq_clr    = tmr_wr || (reg_we && (addr == 8'h00));
    assign adv_en     = tick && !ctrl[0] && !time_wr;
    assign tmr_run    = tick && ctrl[1] && ({tmr_min, tmr_sec} != 16'h0000);
    assign dec_en     = tmr_run && !tmr_wr;
    assign tmr_expire = dec_en && ({tmr_min_dec, tmr_sec_dec} == 16'h0000);

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr    <= 8'h00;
            ctrl    <= 8'h00;
            sec     <= 8'h00;
            minute  <= 8'h00;
            hour    <= 8'h00;
            day     <= 8'h01;
            month   <= 8'h01;
            year    <= 8'h00;
            tmr_sec <= 8'h00;
            tmr_min <= 8'h00;
            irq     <= 1'b1;
        end else begin
            if (addr_we)
                addr <= wdata;
            if (reg_we && (addr == 8'h00))
                ctrl <= wdata;
            if (time_wr) begin
                case (addr)
                    8'h21:   sec    <= wdata;
                    8'h22:   minute <= wdata;
                    8'h23:   hour   <= wdata;
                    8'h24:   day    <= wdata;
                    8'h25:   month  <= wdata;
                    default: year   <= wdata;
                endcase
            end else if (adv_en) begin
                sec    <= sec_adv;
                minute <= min_adv;
                hour   <= hour_adv;
                day    <= day_adv;
                month  <= month_adv;
                year   <= year_adv;
            end
            if (tmr_wr) begin
                if (addr == 8'h41)
                    tmr_sec <= wdata;
                else
                    tmr_min <= wdata;
            end else if (dec_en) begin
                tmr_sec <= tmr_sec_dec;
                tmr_min <= tmr_min_dec;
            end
            if (irq_clr)
                irq <= 1'b1;
            else if (tmr_expire)
                irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed plus randomized bus traffic against a decimal-arithmetic model of the RTC.
module tb_rtc_bus_responder;

    localparam int TICK_DIV = 4;
    localparam int TMAX [6] = '{59, 59, 23, 31, 12, 99};
    localparam int TMIN [6] = '{0, 0, 0, 1, 1, 0};

    logic       clk = 1'b0;
    logic       reset;
    logic       irq;
    wire  [7:0] DatAdd;
    logic [7:0] drv;
    logic       drv_en;

    assign DatAdd = drv_en ? drv : 8'bz;
    wire released = (DatAdd === 8'hzz);

    rtc_bus_responder_if bus ();

    rtc_bus_responder #(.TICK_DIV(TICK_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .DatAdd (DatAdd),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: calendar fields indexed sec..year, timer, ctrl, irq, tick phase.
    logic [7:0] tm [6];
    logic [7:0] m_ctrl, t_sec, t_min;
    logic       m_irq;
    int         k;
    logic       pend_we;
    logic [7:0] pend_a, pend_d, last_addr;

    function automatic int dec2(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] enc2(input int n);
        logic [3:0] h, l;
        h = 4'(n / 10);
        l = 4'(n % 10);
        return {h, l};
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a == 8'h00) return m_ctrl;
        if (a >= 8'h21 && a <= 8'h26) return tm[int'(a) - 33];
        if (a == 8'h41) return t_sec;
        if (a == 8'h42) return t_min;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_ctrl = 8'h00;
        for (int i = 0; i < 6; i++) tm[i] = enc2(TMIN[i]);
        t_sec = 8'h00;
        t_min = 8'h00;
        m_irq = 1'b1;
    endtask

    task automatic model_edge();
        bit         tk, time_wr, tmr_wr, expire;
        logic [7:0] octrl;
        int         r;
        if (!reset) begin
            model_reset();
            k       = 0;
            pend_we = 1'b0;
            return;
        end
        tk      = ((k % TICK_DIV) == TICK_DIV - 1);
        time_wr = pend_we && pend_a >= 8'h21 && pend_a <= 8'h26;
        tmr_wr  = pend_we && (pend_a == 8'h41 || pend_a == 8'h42);
        octrl   = m_ctrl;
        expire  = 1'b0;
        if (tk && !octrl[0] && !time_wr) begin
            for (int i = 0; i < 6; i++) begin
                if (dec2(tm[i]) == TMAX[i]) tm[i] = enc2(TMIN[i]);
                else begin
                    tm[i] = enc2(dec2(tm[i]) + 1);
                    break;
                end
            end
        end
        if (tk && octrl[1] && !tmr_wr) begin
            r = dec2(t_min) * 60 + dec2(t_sec);
            if (r != 0) begin
                r      = r - 1;
                t_min  = enc2(r / 60);
                t_sec  = enc2(r % 60);
                expire = (r == 0);
            end
        end
        if (pend_we) begin
            if (pend_a == 8'h00) m_ctrl = pend_d;
            else if (pend_a == 8'h41) t_sec = pend_d;
            else if (pend_a == 8'h42) t_min = pend_d;
            else if (time_wr) tm[int'(pend_a) - 33] = pend_d;
        end
        if (pend_we && (pend_a == 8'h00 || tmr_wr)) m_irq = 1'b1;
        else if (expire) m_irq = 1'b0;
        k       = k + 1;
        pend_we = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic bus_addr(input logic [7:0] a);
        bus.CS = 1'b0; bus.AD = 1'b0; drv = a; drv_en = 1'b1; bus.WR = 1'b0;
        step();
        bus.WR = 1'b1;
        step();
        last_addr = a;
        bus.CS = 1'b1; drv_en = 1'b0;
        step();
    endtask

    task automatic bus_wdata(input logic [7:0] d, input bit align, input bit abort);
        bus.CS = 1'b0; bus.AD = 1'b1; drv = d; drv_en = 1'b1; bus.WR = 1'b0;
        step();
        if (align) while ((k % TICK_DIV) != TICK_DIV - 1) step();
        if (abort) begin
            bus.CS = 1'b1;
            step();
            bus.WR = 1'b1;
        end else begin
            bus.WR  = 1'b1;
            pend_we = 1'b1; pend_a = last_addr; pend_d = d;
            step();
            bus.CS = 1'b1;
        end
        drv_en = 1'b0;
        step();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input bit align);
        bus_addr(a);
        bus_wdata(d, align, 1'b0);
    endtask

    task automatic bus_read(input logic [7:0] a, input string tag);
        logic [7:0] exp;
        bus_addr(a);
        exp = model_read(a);
        bus.CS = 1'b0; bus.AD = 1'b1; bus.RD = 1'b0;
        #1;
        chk({tag, "_pre"}, {7'b0, released}, 8'h01);
        step();
        chk(tag, DatAdd, exp);
        step();
        step();
        chk({tag, "_hold"}, DatAdd, exp);
        bus.RD = 1'b1;
        #1;
        chk({tag, "_off"}, {7'b0, released}, 8'h01);
        step();
        bus.CS = 1'b1;
        step();
    endtask

    task automatic pick(input int sel, output logic [7:0] a, output logic [7:0] d);
        a = 8'h30;
        d = 8'($urandom_range(0, 255));
        if (sel == 0) begin
            a = 8'h00; d = 8'($urandom_range(0, 3));
        end else if (sel >= 1 && sel <= 6) begin
            a = 8'(8'h20 + sel);
            d = enc2(int'($urandom_range(TMIN[sel-1], TMAX[sel-1])));
        end else if (sel == 7) begin
            a = 8'h41; d = enc2(int'($urandom_range(0, 59)));
        end else if (sel == 8) begin
            a = 8'h42; d = enc2(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, d;
        bus.CS = 1'b1; bus.AD = 1'b0; bus.RD = 1'b1; bus.WR = 1'b1;
        drv = 8'h00; drv_en = 1'b0; pend_we = 1'b0; k = 0; last_addr = 8'h00;
        model_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        chk("rst_irq", {7'b0, irq}, 8'h01);
        chk("rst_bus", {7'b0, released}, 8'h01);
        bus_read(8'h24, "rst_day");
        bus_read(8'h21, "rst_sec");

        bus_write(8'h00, 8'h01, 1'b0);
        bus_write(8'h22, 8'h45, 1'b0);
        bus_read(8'h22, "min_45");

        bus_write(8'h23, 8'h23, 1'b0);
        bus_write(8'h22, 8'h59, 1'b0);
        bus_write(8'h21, 8'h59, 1'b0);
        bus_write(8'h24, 8'h31, 1'b0);
        bus_write(8'h25, 8'h12, 1'b0);
        bus_write(8'h26, 8'h99, 1'b0);
        bus_write(8'h00, 8'h00, 1'b1);
        bus_write(8'h00, 8'h01, 1'b0);
        bus_read(8'h21, "roll_sec");
        bus_read(8'h22, "roll_min");
        bus_read(8'h23, "roll_hour");
        bus_read(8'h24, "roll_day");
        bus_read(8'h25, "roll_month");
        bus_read(8'h26, "roll_year");

        bus_write(8'h42, 8'h01, 1'b0);
        bus_write(8'h41, 8'h00, 1'b0);
        bus_write(8'h00, 8'h02, 1'b0);
        bus_read(8'h41, "tmr_sec_first");
        bus_read(8'h42, "tmr_min_first");
        chk("tmr_irq_running", {7'b0, irq}, {7'b0, m_irq});
        for (int i = 0; i < 400; i++) begin
            step();
            chk("tmr_irq_track", {7'b0, irq}, {7'b0, m_irq});
            if (m_irq == 1'b0) break;
        end
        chk("tmr_irq_expired", {7'b0, irq}, 8'h00);
        bus_read(8'h41, "tmr_sec_zero");
        bus_read(8'h42, "tmr_min_zero");
        chk("tmr_irq_after_reads", {7'b0, irq}, 8'h00);
        bus_write(8'h00, 8'h02, 1'b0);
        chk("tmr_irq_cleared", {7'b0, irq}, 8'h01);

        bus_write(8'h00, 8'h00, 1'b0);
        bus_write(8'h22, 8'h30, 1'b0);
        bus_write(8'h21, 8'h59, 1'b0);
        bus_write(8'h21, 8'h10, 1'b1);
        bus_write(8'h00, 8'h01, 1'b0);
        bus_read(8'h21, "coll_sec");
        bus_read(8'h22, "coll_min");
        bus_read(8'h21, "halt_sec_a");
        repeat (20) step();
        bus_read(8'h21, "halt_sec_b");

        bus_addr(8'h23);
        bus_wdata(8'h07, 1'b0, 1'b1);
        bus_read(8'h23, "abort_hour");

        bus_addr(8'h22);
        bus.CS = 1'b0; bus.AD = 1'b1; bus.RD = 1'b0;
        a = model_read(8'h22);
        step();
        chk("rstrd_drive", DatAdd, a);
        reset = 1'b0;
        #1;
        chk("rstrd_release_now", {7'b0, released}, 8'h01);
        step();
        chk("rstrd_release_next", {7'b0, released}, 8'h01);
        chk("rstrd_irq", {7'b0, irq}, 8'h01);
        bus.RD = 1'b1; bus.CS = 1'b1;
        reset = 1'b1;
        step();
        bus_read(8'h7F, "unmapped_7f");
        bus_read(8'h24, "post_rst_day");
        bus_read(8'h00, "post_rst_ctrl");

        for (int n = 0; n < 40; n++) begin
            pick(int'($urandom_range(0, 9)), a, d);
            if ($urandom_range(0, 2) != 0)
                bus_write(a, d, 1'($urandom_range(0, 1)));
            else
                bus_read(a, "rnd_read");
            chk("rnd_irq", {7'b0, irq}, {7'b0, m_irq});
        end
        for (int i = 0; i < 9; i++) begin
            pick(i, a, d);
            bus_read(a, "final_read");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Synthesizable model of the external RTC chip; the slave end of the multiplexed address/data bus that the RTC controller drives with CS, AD, RD, WR and the shared 8-bit DatAdd.
- Holds BCD time/date registers and a countdown timer, advances them from an internal one-second tick, and asserts irq low on timer expiry.
- Used in-FPGA and in benches to exercise the controller without the physical chip.

Parameters:
TICK_DIV, 100000000, clk cycles per one-second tick (must be >=4)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset (reset==0 resets on next posedge)
CS  input  1  chip select, active low
AD  input  1  0 = address phase, 1 = data phase
RD  input  1  read strobe, active low
WR  input  1  write strobe, active low
DatAdd  inout  8  multiplexed address/data bus; driven only during read data phase, else 8'bz
irq  output  1  active-low timer interrupt

Behaviour:
- Reset (reset==0 at posedge): FSM->IDLE, addr latch=0x00, DatAdd released (z), irq=1, tick counter=0, ctrl=0x00, sec/min/hour=0x00, day/month=0x01, year=0x00, timer regs=0x00.
- Bus inputs sampled each posedge; strobe edges detected by comparing to registered previous value (WR/RD rising = prev 0, now 1).
- FSM states: IDLE, ADDR, WDATA, RDATA.
  - IDLE: CS=0 & AD=0 & WR=0 -> ADDR. CS=0 & AD=1 & WR=0 -> WDATA. CS=0 & AD=1 & RD=0 -> RDATA. WR and RD both low -> stay IDLE (illegal, ignored).
  - ADDR: on WR rising, latch DatAdd into addr, -> IDLE. CS=1 before WR rises -> IDLE, no latch.
  - WDATA: on WR rising, write DatAdd into reg[addr], -> IDLE. CS=1 first -> abort, no write.
  - RDATA: drive reg[addr] from the cycle after RD low is first sampled (1-cycle latency). Value is captured at RDATA entry and held stable. On RD=1 or CS=1, release bus same cycle (combinational off) -> IDLE.
- Register map, BCD:
  - 0x00 ctrl: bit0 = halt clock; bit1 = timer enable.
  - 0x21 sec, 0x22 min, 0x23 hour (24 h).
  - 0x24 day, 0x25 month, 0x26 year.
  - 0x41 timer sec, 0x42 timer min.
  - Unmapped read -> 0x00; unmapped write ignored.
- Tick: counter counts 0..TICK_DIV-1 and pulses at wrap. It counts even when halted.
- Clock advance on tick when ctrl[0]=0:
  - sec 0x59->0x00 carries to min.
  - min 0x59->0x00 carries to hour.
  - hour 0x23->0x00 carries to day.
  - day 0x31->0x01 carries to month (fixed 31-day months, no leap handling).
  - month 0x12->0x01 carries to year.
  - year 0x99->0x00.
  - Low nibble 9->0 carries to high nibble.
- Timer on tick when ctrl[1]=1 and {min,sec}!=0: BCD decrement (sec 0x00 borrows from min, becomes 0x59). Transition to 0x0000 sets irq=0.
- irq clears (=1) on any write to ctrl, 0x41 or 0x42; unaffected by reads.
- Simultaneous bus write and tick:
  - Write to any time/date register: the write wins and that tick's clock advance is discarded entirely.
  - Write to a timer register: the write wins and that tick's decrement is discarded.
  - Other registers still update normally.
- Non-BCD values written are stored as-is. Increment treats a low nibble >=9 as carry and resets it to 0. A high-nibble overflow beyond the limit wraps to the reset value of that field.
- reset low mid-transaction: immediate reset state, bus released that cycle.

Test Plan:
- Reset low 2 cycles, release -> irq=1, DatAdd=z, read 0x24 returns 0x01, read 0x21 returns 0x00.
- Address 0x22 phase, data write 0x45, then read 0x22 -> DatAdd=0x45 from 1 cycle after RD low; z the cycle RD returns high.
- TICK_DIV=4, write hour=0x23 min=0x59 sec=0x59 day=0x31 month=0x12 year=0x99, one tick -> all 0x00 except day=0x01 month=0x01.
- TICK_DIV=4, timer min=0x01 sec=0x00, ctrl=0x02 -> after 1 tick timer=0x00/0x59; after 60 ticks irq=0. Write ctrl=0x02 -> irq=1.
- Write sec=0x10 on the exact tick cycle -> sec reads 0x10 (not 0x11) and min unchanged. With ctrl=0x01, ticks leave sec unchanged.
- Abort cases: CS high before WR rises in WDATA -> register unchanged. Reset asserted during RDATA -> DatAdd=z next cycle. Read of 0x7F -> 0x00.
